// File: rtl/win_checker_if.sv
// win_checker_if: bundles the game-controller handshake and the board-storage
// read port used by win_checker.
//   start/last_row/last_col/player : check request from the game controller
//   busy/done/win                  : check status and result
//   rd_en/rd_row/rd_col            : board read request (combinational read)
//   rd_data                        : board cell contents, same-cycle return
// Modports: slave = the checker, master = its environment (controller + board).
interface win_checker_if;
  logic       start;
  logic [2:0] last_row;
  logic [2:0] last_col;
  logic [1:0] player;
  logic       rd_en;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic       win;

  modport master (
    output start, last_row, last_col, player, rd_data,
    input  rd_en, rd_row, rd_col, busy, done, win
  );

  modport slave (
    input  start, last_row, last_col, player, rd_data,
    output rd_en, rd_row, rd_col, busy, done, win
  );
endinterface

// File: rtl/win_checker.sv
// win_checker: post-move Connect Four win detector. After start it probes the
// 7-cell window (offsets -3..+3) around the last piece in four directions,
// one board read per cycle, and reports whether CONNECT consecutive cells
// belong to the player. Always 28 scan cycles, then a one-cycle done pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active-high
//   bus   : win_checker_if.slave (request, board read port, busy/done/win)
//
// state | meaning
// IDLE  | waiting for start; win holds the last result
// SCAN  | 4 directions x 7 offsets, one board probe per cycle
// DONE  | one-cycle done pulse, win already valid
module win_checker #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int CONNECT = 4
) (
  input  logic          clk,
  input  logic          rst,
  win_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [2:0]        RUN_MAX = 3'(CONNECT);
  localparam logic signed [4:0] ROW_LIM = 5'(ROWS);
  localparam logic signed [4:0] COL_LIM = 5'(COLS);

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [1:0] player_q, player_d;
  logic [1:0] dir_q, dir_d;
  logic [2:0] kidx_q, kidx_d;   // offset k = kidx - 3
  logic [2:0] run_q, run_d;
  logic       hit_q, hit_d;
  logic       win_q, win_d;

  logic signed [4:0] k_s, r_s, c_s;
  logic              on_board;
  logic              match;
  logic [2:0]        run_nxt;

  // Probe coordinate for the current direction/offset.
  always_comb begin
    k_s = $signed({2'b00, kidx_q}) - 5'sd3;
    r_s = $signed({2'b00, row_q});
    c_s = $signed({2'b00, col_q});
    case (dir_q)
      2'd0: c_s = c_s + k_s;
      2'd1: r_s = r_s + k_s;
      2'd2: begin
        r_s = r_s + k_s;
        c_s = c_s + k_s;
      end
      default: begin
        r_s = r_s + k_s;
        c_s = c_s - k_s;
      end
    endcase
    on_board = !r_s[4] && (r_s < ROW_LIM) && !c_s[4] && (c_s < COL_LIM);
    // Off-board probes never match, whatever rd_data happens to carry.
    match    = on_board && (bus.rd_data == player_q) && (player_q != 2'b00);
    run_nxt  = 3'd0;
    if (match) begin
      run_nxt = (run_q == RUN_MAX) ? RUN_MAX : run_q + 3'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    player_d   = player_q;
    dir_d      = dir_q;
    kidx_d     = kidx_q;
    run_d      = run_q;
    hit_d      = hit_q;
    win_d      = win_q;
    bus.rd_en  = 1'b0;
    bus.rd_row = 3'd0;
    bus.rd_col = 3'd0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.win    = win_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          row_d    = bus.last_row;
          col_d    = bus.last_col;
          player_d = bus.player;
          win_d    = 1'b0;
          dir_d    = 2'd0;
          kidx_d   = 3'd0;
          run_d    = 3'd0;
          hit_d    = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        bus.busy  = 1'b1;
        bus.rd_en = on_board;
        if (on_board) begin
          bus.rd_row = r_s[2:0];
          bus.rd_col = c_s[2:0];
        end
        run_d = run_nxt;
        hit_d = hit_q || (run_nxt == RUN_MAX);
        if (kidx_q == 3'd6) begin
          kidx_d = 3'd0;
          run_d  = 3'd0;
          dir_d  = dir_q + 2'd1;
          if (dir_q == 2'd3) begin
            // Include the final probe's hit so win is valid during DONE.
            win_d   = hit_d;
            state_d = DONE;
          end
        end else begin
          kidx_d = kidx_q + 3'd1;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      player_q <= 2'b00;
      dir_q    <= 2'd0;
      kidx_q   <= 3'd0;
      run_q    <= 3'd0;
      hit_q    <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      player_q <= player_d;
      dir_q    <= dir_d;
      kidx_q   <= kidx_d;
      run_q    <= run_d;
      hit_q    <= hit_d;
      win_q    <= win_d;
    end
  end

endmodule

// File: tb/tb_win_checker.sv
// tb_win_checker: table-driven directed vectors, hand-written corner sequences
// (ignored mid-scan start, reset abort) and randomized boards checked against
// a window-search reference model of the win rule.
module tb_win_checker;
  localparam int CONNECT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  win_checker_if bif();

  win_checker #(.ROWS(8), .COLS(8), .CONNECT(CONNECT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  logic [1:0] board [8][8];
  logic [1:0] fill_p;
  // When not enabled, return the player's own code so a design that used
  // off-board data would score a false match.
  always_comb bif.rd_data = bif.rd_en ? board[bif.rd_row][bif.rd_col] : fill_p;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    int         brd;
    int         lr;
    int         lc;
    logic [1:0] pl;
    logic       ew;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string n, input int b, input int r, input int c,
                     input logic [1:0] p, input logic w);
    vec_t v;
    v.name = n; v.brd = b; v.lr = r; v.lc = c; v.pl = p; v.ew = w;
    tbl.push_back(v);
  endtask

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  function automatic int dr_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int dc_of(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic bit inside_board(input int r, input int c);
    return r >= 0 && r <= 7 && c >= 0 && c <= 7;
  endfunction

  // Win iff some CONNECT-long segment inside the -3..+3 window of a direction
  // is entirely on-board and owned by the player.
  function automatic logic model_win(input int lr, input int lc, input logic [1:0] p);
    if (p == 2'b00) return 1'b0;
    for (int d = 0; d < 4; d++) begin
      for (int s = -3; s <= 4 - CONNECT; s++) begin
        bit ok = 1'b1;
        for (int j = 0; j < CONNECT; j++) begin
          int r = lr + dr_of(d) * (s + j);
          int c = lc + dc_of(d) * (s + j);
          if (!inside_board(r, c)) ok = 1'b0;
          else if (board[r][c] != p) ok = 1'b0;
        end
        if (ok) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic set_board(input int id);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        board[r][c] = 2'b00;
    case (id)
      1: for (int c = 2; c <= 5; c++) board[0][c] = 2'b01;
      2: for (int r = 0; r <= 3; r++) board[r][3] = 2'b10;
      3: for (int i = 0; i <= 3; i++) board[i][7-i] = 2'b01;
      4: begin
        board[2][0] = 2'b01; board[2][1] = 2'b01; board[2][2] = 2'b01;
        board[2][3] = 2'b10; board[2][4] = 2'b01;
      end
      default: ;
    endcase
  endtask

  // One full check: start, per-cycle probe checks, done/win timing.
  // inject_at >= 0 pulses a conflicting start at that scan cycle;
  // abort_at >= 0 asserts rst at that scan cycle instead of completing.
  task automatic run_scan(input string name, input int lr, input int lc,
                          input logic [1:0] pl, input logic ew,
                          input int inject_at, input int abort_at);
    @(negedge clk);
    bif.start    = 1'b1;
    bif.last_row = 3'(lr);
    bif.last_col = 3'(lc);
    bif.player   = pl;
    fill_p       = pl;
    for (int i = 0; i < 28; i++) begin
      int  d = i / 7;
      int  k = i % 7 - 3;
      int  r = lr + dr_of(d) * k;
      int  c = lc + dc_of(d) * k;
      bit  en = inside_board(r, c);
      @(negedge clk);
      bif.start = 1'b0;
      check({name, ".busy"}, 32'(bif.busy), 32'd1);
      check({name, ".done_early"}, 32'(bif.done), 32'd0);
      check({name, ".rd_en"}, 32'(bif.rd_en), 32'(en));
      check({name, ".rd_row"}, 32'(bif.rd_row), en ? 32'(r) : 32'd0);
      check({name, ".rd_col"}, 32'(bif.rd_col), en ? 32'(c) : 32'd0);
      if (i == inject_at) begin
        bif.start    = 1'b1;
        bif.last_row = 3'(7 - lr);
        bif.last_col = 3'(7 - lc);
        bif.player   = ~pl;
      end
      if (i == abort_at) begin
        bit saw_done = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({name, ".abort_busy"}, 32'(bif.busy), 32'd0);
        check({name, ".abort_done"}, 32'(bif.done), 32'd0);
        check({name, ".abort_win"}, 32'(bif.win), 32'd0);
        check({name, ".abort_rd_en"}, 32'(bif.rd_en), 32'd0);
        for (int j = 0; j < 35; j++) begin
          @(negedge clk);
          if (bif.done || bif.busy) saw_done = 1'b1;
        end
        check({name, ".no_done_after_abort"}, 32'(saw_done), 32'd0);
        return;
      end
    end
    @(negedge clk);
    bif.start = 1'b0;
    check({name, ".done"}, 32'(bif.done), 32'd1);
    check({name, ".busy_in_done"}, 32'(bif.busy), 32'd0);
    check({name, ".rd_en_in_done"}, 32'(bif.rd_en), 32'd0);
    check({name, ".win"}, 32'(bif.win), 32'(ew));
    @(negedge clk);
    check({name, ".done_pulse"}, 32'(bif.done), 32'd0);
    check({name, ".win_hold"}, 32'(bif.win), 32'(ew));
  endtask

  initial begin
    bif.start    = 1'b0;
    bif.last_row = 3'd0;
    bif.last_col = 3'd0;
    bif.player   = 2'b00;
    fill_p       = 2'b00;
    set_board(0);

    add("t1_row_win",     1, 0, 5, 2'b01, 1'b1);
    add("t1_row_left",    1, 0, 2, 2'b01, 1'b1);
    add("t1_row_short",   1, 0, 1, 2'b01, 1'b0);
    add("t1_empty_pl",    1, 0, 5, 2'b00, 1'b0);
    add("t2_col_win",     2, 3, 3, 2'b10, 1'b1);
    add("t2_col_otherpl", 2, 3, 3, 2'b01, 1'b0);
    add("t3_anti_win",    3, 0, 7, 2'b01, 1'b1);
    add("t3_anti_bot",    3, 3, 4, 2'b01, 1'b1);
    add("t4_gap",         4, 2, 4, 2'b01, 1'b0);
    add("empty_board",    0, 0, 0, 2'b01, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy",   32'(bif.busy),   32'd0);
    check("reset.done",   32'(bif.done),   32'd0);
    check("reset.win",    32'(bif.win),    32'd0);
    check("reset.rd_en",  32'(bif.rd_en),  32'd0);
    check("reset.rd_row", 32'(bif.rd_row), 32'd0);
    check("reset.rd_col", 32'(bif.rd_col), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_board(tbl[i].brd);
      run_scan(tbl[i].name, tbl[i].lr, tbl[i].lc, tbl[i].pl, tbl[i].ew, -1, -1);
    end

    // Conflicting start mid-scan must be ignored.
    set_board(1);
    run_scan("ignore_start", 0, 5, 2'b01, 1'b1, 5, -1);

    // Reset mid-scan after a winning result, then a fresh check.
    run_scan("pre_abort", 0, 5, 2'b01, 1'b1, -1, -1);
    run_scan("abort", 0, 5, 2'b01, 1'b1, -1, 10);
    run_scan("after_abort", 0, 5, 2'b01, 1'b1, -1, -1);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] p;
      int lr, lc;
      p  = 2'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 3));
      lr = $urandom_range(0, 7);
      lc = $urandom_range(0, 7);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r][c] = ($urandom_range(0, 2) != 0) ? p : 2'($urandom_range(0, 3));
      run_scan($sformatf("rand%0d", n), lr, lc, p, model_win(lr, lc, p), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
